// File: rtl/ram_io_pkg.sv
// Shared constants and types for the byte-wide memory responder.
// I/O map: IO_DATA (console data) and IO_STAT (status / halt), selected by address bit IO_SEL_BIT.
package ram_io_pkg;

  typedef logic [7:0] byte_t;

  localparam int IO_SEL_BIT = 17;
  localparam int DEC_W      = IO_SEL_BIT + 1;

  localparam logic [DEC_W-1:0] IO_DATA = 18'h30000;
  localparam logic [DEC_W-1:0] IO_STAT = 18'h30004;

  localparam int STAT_TX_EMPTY = 0;
  localparam int STAT_TX_FULL  = 1;
  localparam int STAT_OVF      = 2;
  localparam int STAT_RX_AVAIL = 3;

  function automatic byte_t stat_byte(input logic rx_avail, input logic ovf,
                                      input logic tx_full, input logic tx_empty);
    byte_t s;
    s                = '0;
    s[STAT_RX_AVAIL] = rx_avail;
    s[STAT_OVF]      = ovf;
    s[STAT_TX_FULL]  = tx_full;
    s[STAT_TX_EMPTY] = tx_empty;
    return s;
  endfunction

endpackage

// File: rtl/ram_io_responder_fifo.sv
// byte_fifo: power-of-two byte FIFO with combinational head and wrap-bit pointers.
// A push while full is accepted only if a pop happens on the same edge.
module byte_fifo
  import ram_io_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  push,
  input  byte_t din,
  input  logic  pop,
  output byte_t head,
  output logic  full,
  output logic  empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_INC = {{AW{1'b0}}, 1'b1};

  byte_t       mem [DEPTH];
  logic [AW:0] wr_ptr_reg;
  logic [AW:0] rd_ptr_reg;
  logic        push_ok;
  logic        pop_ok;

  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr_reg[AW-1:0]];

  // When full, the write slot equals the slot being popped; head is read before the edge.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_INC;
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_INC;
      end
    end
  end

endmodule

// File: rtl/ram_io_responder.sv
// Byte-bus responder: on-chip RAM plus console TX FIFO, status and halt I/O window.
// Define IO_RX_EN to add the console RX FIFO behind IO_DATA reads.
module ram_io_responder
  import ram_io_pkg::*;
#(
  parameter int RAM_AW   = 17,
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_dout,
  input  logic        mem_wr,
  output logic [7:0]  mem_din,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        sim_halt,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);

  logic [DEC_W-1:0]  dec_addr;
  logic [RAM_AW-1:0] ram_addr;
  logic              io_sel;
  logic              hit_data;
  logic              hit_stat;
  logic              run_start;

  logic [DEC_W-1:0]  prev_addr_reg;
  logic              prev_wr_reg;
  logic              prev_valid_reg;

  logic              tx_push;
  logic              tx_pop;
  logic              tx_full;
  logic              tx_empty;
  logic              ovf_reg;
  logic              sim_halt_reg;

  logic              rx_avail;
  byte_t             rx_rd_byte;
  byte_t             io_rd_byte;

  byte_t             ram [2**RAM_AW];
  byte_t             ram_q_reg;
  byte_t             io_q_reg;
  logic              src_io_reg;

  assign dec_addr = mem_a[DEC_W-1:0];
  assign ram_addr = mem_a[RAM_AW-1:0];

  always_comb begin
    io_sel    = dec_addr[IO_SEL_BIT];
    hit_data  = io_sel && (dec_addr == IO_DATA);
    hit_stat  = io_sel && (dec_addr == IO_STAT);
    run_start = !prev_valid_reg || (dec_addr != prev_addr_reg) || (mem_wr != prev_wr_reg);
  end

  // Previous-cycle access, so I/O side effects fire once per run of identical cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_valid_reg <= 1'b0;
      prev_addr_reg  <= '0;
      prev_wr_reg    <= 1'b0;
    end else begin
      prev_valid_reg <= 1'b1;
      prev_addr_reg  <= dec_addr;
      prev_wr_reg    <= mem_wr;
    end
  end

  assign tx_push  = mem_wr && hit_data && run_start;
  assign tx_valid = !tx_empty;
  assign tx_pop   = tx_valid && tx_ready;

  byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .din   (mem_dout),
    .pop   (tx_pop),
    .head  (tx_data),
    .full  (tx_full),
    .empty (tx_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_reg      <= 1'b0;
      sim_halt_reg <= 1'b0;
    end else begin
      if (tx_push && tx_full && !tx_pop) begin
        ovf_reg <= 1'b1;
      end else if (!mem_wr && hit_stat && run_start) begin
        ovf_reg <= 1'b0;
      end
      if (mem_wr && hit_stat && run_start) begin
        sim_halt_reg <= 1'b1;
      end
    end
  end

  assign sim_halt = sim_halt_reg;

`ifdef IO_RX_EN
  logic  rx_full;
  logic  rx_empty;
  logic  rx_pop;
  byte_t rx_head;

  assign rx_ready = !rx_full;
  assign rx_avail = !rx_empty;
  assign rx_pop   = !mem_wr && hit_data && run_start && !rx_empty;

  byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_valid && !rx_full),
    .din   (rx_data),
    .pop   (rx_pop),
    .head  (rx_head),
    .full  (rx_full),
    .empty (rx_empty)
  );

  assign rx_rd_byte = rx_pop ? rx_head : 8'h00;

  logic unused_bits;
  assign unused_bits = &{1'b0, mem_a[31:DEC_W]};
`else
  assign rx_ready   = 1'b0;
  assign rx_avail   = 1'b0;
  assign rx_rd_byte = 8'h00;

  logic unused_bits;
  assign unused_bits = &{1'b0, mem_a[31:DEC_W], rx_data, rx_valid, RX_DEPTH[0]};
`endif

  always_comb begin
    io_rd_byte = 8'h00;
    if (hit_stat) begin
      io_rd_byte = stat_byte(rx_avail, ovf_reg, tx_full, tx_empty);
    end else if (hit_data) begin
      io_rd_byte = rx_rd_byte;
    end
  end

  // RAM write and read-first registered read; write cycles leave the read register alone.
  always_ff @(posedge clk) begin
    if (mem_wr && !io_sel) begin
      ram[ram_addr] <= mem_dout;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ram_q_reg <= 8'h00;
    end else if (!mem_wr && !io_sel) begin
      ram_q_reg <= ram[ram_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      src_io_reg <= 1'b0;
      io_q_reg   <= 8'h00;
    end else if (!mem_wr) begin
      src_io_reg <= io_sel;
      if (io_sel) begin
        io_q_reg <= io_rd_byte;
      end
    end
  end

  assign mem_din = src_io_reg ? io_q_reg : ram_q_reg;

endmodule

// File: tb/tb_ram_io_responder.sv
// Directed bench for ram_io_responder: read-data and TX-byte scoreboards checked by immediate asserts.
// Build with IO_RX_EN defined to also exercise the RX path.
module tb_ram_io_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] mem_a = '0;
  logic [7:0]  mem_dout = '0;
  logic        mem_wr = 1'b0;
  logic [7:0]  mem_din;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        sim_halt;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0] din_q[$];
  logic [7:0] tx_q[$];
  logic [7:0] last_din = 8'h00;

  ram_io_responder dut (
    .clk      (clk),
    .rst      (rst),
    .mem_a    (mem_a),
    .mem_dout (mem_dout),
    .mem_wr   (mem_wr),
    .mem_din  (mem_din),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .sim_halt (sim_halt),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready)
  );

  always #5 clk = ~clk;

  task automatic check8(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests_run++;
    assert (got === exp) else begin
      tests_failed++;
      $error("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  // One bus cycle; reads expect exp, writes expect mem_din to hold its last value.
  task automatic bus(input string tag, input logic [31:0] a, input logic wr,
                     input logic [7:0] d, input logic [7:0] exp);
    mem_a    = a;
    mem_wr   = wr;
    mem_dout = d;
    if (wr) din_q.push_back(last_din);
    else    din_q.push_back(exp);
    @(posedge clk);
    #1;
    last_din = din_q.pop_front();
    check8(tag, mem_din, last_din);
  endtask

  task automatic filler();
    bus("filler", 32'h0000_0010, 1'b0, 8'h00, 8'hA5);
  endtask

  // Every byte the harness accepts must be the next one the bench expects.
  always @(negedge clk) begin
    if (!rst && tx_valid && tx_ready) begin
      tests_run++;
      assert (tx_q.size() > 0) else begin
        tests_failed++;
        $error("FAIL tx_extra: got %02h expected none", tx_data);
      end
      if (tx_q.size() > 0) check8("tx_data", tx_data, tx_q.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check8("rst_mem_din", mem_din, 8'h00);
    check8("rst_tx_valid", {7'b0, tx_valid}, 8'h00);
    check8("rst_sim_halt", {7'b0, sim_halt}, 8'h00);
`ifdef IO_RX_EN
    check8("rst_rx_ready", {7'b0, rx_ready}, 8'h01);
`else
    check8("rst_rx_ready", {7'b0, rx_ready}, 8'h00);
`endif
    bus("stat_reset", 32'h0003_0004, 1'b0, 8'h00, 8'h01);

    // RAM write then read, one-cycle latency
    bus("ram_wr_a5", 32'h0000_0010, 1'b1, 8'hA5, 8'h00);
    bus("ram_rd_a5", 32'h0000_0010, 1'b0, 8'h00, 8'hA5);

    // Old data returned, write cycle holds mem_din, later read sees new data
    bus("ram_wr_11", 32'h0000_0020, 1'b1, 8'h11, 8'h00);
    bus("ram_rd_11", 32'h0000_0020, 1'b0, 8'h00, 8'h11);
    bus("ram_wr_3c_hold", 32'h0000_0020, 1'b1, 8'h3C, 8'h00);
    bus("ram_rd_3c", 32'h0000_0020, 1'b0, 8'h00, 8'h3C);

    // Unmapped I/O
    bus("unmap_wr", 32'h0003_0008, 1'b1, 8'h55, 8'h00);
    bus("unmap_rd", 32'h0003_0008, 1'b0, 8'h00, 8'h00);
    bus("unmap_rd2", 32'h0002_0000, 1'b0, 8'h00, 8'h00);

    // Two console bytes with the harness ready
    tx_ready = 1'b1;
    tx_q.push_back(8'h48);
    bus("tx_wr_48", 32'h0003_0000, 1'b1, 8'h48, 8'h00);
    filler();
    tx_q.push_back(8'h69);
    bus("tx_wr_69", 32'h0003_0000, 1'b1, 8'h69, 8'h00);
    filler();
    filler();
    check8("tx_idle", {7'b0, tx_valid}, 8'h00);
    check8("tx_q_empty", 8'(tx_q.size()), 8'h00);
    tx_ready = 1'b0;

    // Overflow: 17 pushes into a 16-deep FIFO
    for (int i = 0; i < 17; i++) begin
      if (i < 16) tx_q.push_back(8'(8'h80 + i));
      bus("ovf_push", 32'h0003_0000, 1'b1, 8'(8'h80 + i), 8'h00);
      filler();
    end
    bus("stat_ovf", 32'h0003_0004, 1'b0, 8'h00, 8'h06);
    filler();
    bus("stat_cleared", 32'h0003_0004, 1'b0, 8'h00, 8'h02);
    tx_ready = 1'b1;
    for (int k = 0; k < 40 && tx_valid; k++) filler();
    check8("ovf_drained", 8'(tx_q.size()), 8'h00);
    check8("ovf_tx_valid", {7'b0, tx_valid}, 8'h00);
    tx_ready = 1'b0;

    // Full with simultaneous pop: push accepted, no overflow
    for (int i = 0; i < 16; i++) begin
      tx_q.push_back(8'(8'h20 + i));
      bus("full_fill", 32'h0003_0000, 1'b1, 8'(8'h20 + i), 8'h00);
      filler();
    end
    tx_ready = 1'b1;
    tx_q.push_back(8'h5A);
    bus("full_pop_push", 32'h0003_0000, 1'b1, 8'h5A, 8'h00);
    bus("stat_full_pop", 32'h0003_0004, 1'b0, 8'h00, 8'h02);
    for (int k = 0; k < 40 && tx_valid; k++) filler();
    check8("full_drained", 8'(tx_q.size()), 8'h00);
    tx_ready = 1'b0;

    // Held write is one push
    tx_q.push_back(8'hC1);
    repeat (3) bus("held_wr", 32'h0003_0000, 1'b1, 8'hC1, 8'h00);
    bus("stat_one", 32'h0003_0004, 1'b0, 8'h00, 8'h00);
    filler();
    tx_ready = 1'b1;
    repeat (3) filler();
    tx_ready = 1'b0;
    check8("held_drained", 8'(tx_q.size()), 8'h00);
    check8("held_tx_valid", {7'b0, tx_valid}, 8'h00);

    // Halt request is sticky
    bus("halt_wr", 32'h0003_0004, 1'b1, 8'h00, 8'h00);
    check8("halt_set", {7'b0, sim_halt}, 8'h01);
    filler();
    filler();
    check8("halt_held", {7'b0, sim_halt}, 8'h01);

`ifdef IO_RX_EN
    rx_data  = 8'h7A;
    rx_valid = 1'b1;
    filler();
    rx_valid = 1'b0;
    bus("stat_rx", 32'h0003_0004, 1'b0, 8'h00, 8'h09);
    bus("rx_rd", 32'h0003_0000, 1'b0, 8'h00, 8'h7A);
    filler();
    bus("rx_rd_empty", 32'h0003_0000, 1'b0, 8'h00, 8'h00);
    bus("stat_rx_done", 32'h0003_0004, 1'b0, 8'h00, 8'h01);
    rx_data  = 8'h33;
    rx_valid = 1'b1;
    filler();
    rx_valid = 1'b0;
`endif

    // Reset mid-transfer: TX byte pending and a read in flight
    bus("pre_rst_push", 32'h0003_0000, 1'b1, 8'hEE, 8'h00);
    mem_a  = 32'h0000_0010;
    mem_wr = 1'b0;
    rst    = 1'b1;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    last_din = 8'h00;
    check8("rst_mid_din", mem_din, 8'h00);
    check8("rst_mid_tx_valid", {7'b0, tx_valid}, 8'h00);
    check8("rst_mid_halt", {7'b0, sim_halt}, 8'h00);
    bus("stat_after_rst", 32'h0003_0004, 1'b0, 8'h00, 8'h01);
    bus("ram_kept", 32'h0000_0020, 1'b0, 8'h00, 8'h3C);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
